mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Consumes mem_ALUout as the effective address and performs byte, half or word loads and stores over a req/ack data-memory bus.
- Stalls the pipeline while an access is outstanding, then hands the aligned, extended result to write-back through registered outputs.

Parameters:
- S, 32, data/address width; only 32 is supported.
- TIMEOUT, 16, max cycles waiting for dm_ack before a bus error (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_valid  in  1  EX/MEM holds a valid instruction.
- mem_ALUout  in  S  effective address, or ALU result for non-memory ops.
- mem_wdata  in  S  store data (rt).
- mem_read  in  1  load instruction.
- mem_write  in  1  store instruction.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_unsigned  in  1  zero-extend loads (lbu/lhu).
- mem_stall  out  1  freeze PC/IF/ID/EX/MEM registers.
- dm_req  out  1  bus request.
- dm_we  out  1  1 = write.
- dm_addr  out  S  word-aligned address ({addr[S-1:2],2'b00}).
- dm_wdata  out  S  lane-replicated store data.
- dm_be  out  4  byte enables, little-endian.
- dm_rdata  in  S  read word.
- dm_ack  in  1  access complete; dm_rdata valid this cycle.
- wb_valid  out  1  valid instruction to MEM/WB.
- wb_ALUout  out  S  passed-through mem_ALUout.
- wb_rdata  out  S  extended load data, 0 for non-loads.
- wb_memread  out  1  instruction was a load.
- wb_misalign  out  1  alignment fault.
- wb_buserr  out  1  bus timeout fault.

Behaviour:
- Reset (async, reset==0):
  - State goes to IDLE immediately.
  - All registered outputs go to 0.
  - mem_stall is forced to 0.
  - A bus access in flight is abandoned: dm_req drops at once.
- FSM states: IDLE, WAIT, RESP.
- IDLE, access = mem_valid & (mem_read|mem_write) & aligned:
  - mem_stall=1 combinationally.
  - Next edge: dm_req=1; dm_we, dm_addr, dm_wdata, dm_be loaded; go to WAIT.
- IDLE, non-access, misaligned access, or !mem_valid:
  - mem_stall=0.
  - wb_* load on the next edge (1-cycle latency).
- WAIT:
  - mem_stall=1 and bus outputs held stable.
  - On the dm_ack edge: capture the extended dm_rdata into the result register, drop dm_req and dm_we, go to RESP.
  - Ack latency 0..N cycles after dm_req rises. dm_ack while dm_req=0 is ignored.
- RESP:
  - mem_stall=0.
  - Next edge: wb_valid=1, wb_rdata=captured result, wb_memread=mem_read, go to IDLE.
  - Minimum load/store occupancy is 3 cycles with same-cycle ack (IDLE, WAIT, RESP).
- Upstream contract: mem_* inputs are held stable while mem_stall=1.
- Alignment:
  - Word needs addr[1:0]==0; half needs addr[0]==0.
  - On a fault: no bus request, store suppressed, wb_misalign=1, wb_rdata=0, wb_valid=1.
- If mem_read and mem_write are both high, the write wins and the load is ignored.
- Store lanes:
  - Byte: dm_be=4'b0001<<addr[1:0]; dm_wdata = byte replicated ×4.
  - Half: dm_be = addr[1] ? 1100 : 0011; dm_wdata = half replicated ×2.
  - Word: dm_be=1111.
- Load extract:
  - Byte lane addr[1:0]; half lane addr[1].
  - Sign-extend unless mem_unsigned.
- !mem_valid passes a bubble: wb_valid=0, all wb_* zeroed.
- wb_misalign and wb_buserr are valid for one wb_valid cycle only.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without dm_ack: drop dm_req, go to RESP with result 0 and wb_buserr=1.
- Undefined:
  - No counter; WAIT persists until dm_ack.
  - wb_buserr is tied to 0.

Test Plan:
- Word load: addr 0x100, dm_rdata 0xDEADBEEF, ack 2 cycles after req -> mem_stall high for 4 cycles, dm_be=1111, wb_rdata=0xDEADBEEF, wb_memread=1.
- Signed vs unsigned byte: lb and lbu at addr 0x103, dm_rdata 0x80FF_FF00 -> lb gives wb_rdata=0xFFFFFF80, lbu gives 0x00000080; dm_addr=0x100 in both.
- Half store: addr 0x22, wdata 0x1234ABCD -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, dm_addr=0x20.
- Misaligned word load: addr 0x102 -> dm_req never rises, no stall, next cycle wb_misalign=1, wb_rdata=0.
- Reset mid-access: assert reset in WAIT with dm_req=1 -> dm_req, mem_stall and wb_valid are 0 immediately; after release, an ALU op passes through in 1 cycle.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT=4: no ack -> dm_req drops after 4 WAIT cycles, wb_buserr=1, wb_rdata=0. Without the macro, the stall persists until ack.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline.
// Issues byte/half/word loads and stores over a req/ack data bus, stalls the
// pipeline while an access is outstanding and registers the aligned,
// extended result towards MEM/WB.
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort an access that sees no
// dm_ack within TIMEOUT wait cycles (reported on wb_buserr).
module mem_access_stage #(
  parameter int unsigned S       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_valid,
  input  logic [S-1:0] mem_ALUout,
  input  logic [S-1:0] mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_size,
  input  logic         mem_unsigned,
  output logic         mem_stall,
  output logic         dm_req,
  output logic         dm_we,
  output logic [S-1:0] dm_addr,
  output logic [S-1:0] dm_wdata,
  output logic [3:0]   dm_be,
  input  logic [S-1:0] dm_rdata,
  input  logic         dm_ack,
  output logic         wb_valid,
  output logic [S-1:0] wb_ALUout,
  output logic [S-1:0] wb_rdata,
  output logic         wb_memread,
  output logic         wb_misalign,
  output logic         wb_buserr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state, state_n;

  logic         is_mem, is_load, sz_word, sz_half;
  logic         misalign, access;
  logic         bus_start, bus_done, bus_tmo;
  logic         wb_idle, wb_resp, stall_c;
  logic [3:0]   be_c;
  logic [S-1:0] wdata_c;
  logic [S-1:0] res_q;

  // Sign/zero-extend the addressed lane of a read word.
  function automatic logic [S-1:0] load_extend(input logic [S-1:0] w,
                                               input logic [1:0]   a,
                                               input logic [1:0]   sz,
                                               input logic         u);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_extend = {{(S-8){b[7] & ~u}}, b};
      2'b01:   load_extend = {{(S-16){h[15] & ~u}}, h};
      default: load_extend = w;
    endcase
  endfunction

  // A write takes precedence over a simultaneous read; reserved size is word.
  assign is_mem   = mem_read | mem_write;
  assign is_load  = mem_read & ~mem_write;
  assign sz_word  = mem_size[1];
  assign sz_half  = (mem_size == 2'b01);
  assign misalign = mem_valid & is_mem &
                    ((sz_word & (mem_ALUout[1:0] != 2'b00)) | (sz_half & mem_ALUout[0]));
  assign access   = mem_valid & is_mem & ~misalign;

  // Byte-enable and lane-replicated write data for the current instruction.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = mem_wdata;
    case (mem_size)
      2'b00: begin
        be_c    = 4'b0001 << mem_ALUout[1:0];
        wdata_c = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = mem_ALUout[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state and control strobes.
  always_comb begin
    state_n   = state;
    bus_start = 1'b0;
    bus_done  = 1'b0;
    wb_idle   = 1'b0;
    wb_resp   = 1'b0;
    stall_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          stall_c   = 1'b1;
          bus_start = 1'b1;
          state_n   = ST_WAIT;
        end else begin
          wb_idle = 1'b1;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (dm_ack) begin
          bus_done = 1'b1;
          state_n  = ST_RESP;
        end else if (bus_tmo) begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        wb_resp = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Stall is combinational from IDLE, so it must be gated while reset is held.
  assign mem_stall = reset & stall_c;

  // Bus request/launch registers and the captured load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_be    <= '0;
      res_q    <= '0;
    end else if (bus_start) begin
      dm_req   <= 1'b1;
      dm_we    <= mem_write;
      dm_addr  <= {mem_ALUout[S-1:2], 2'b00};
      dm_wdata <= wdata_c;
      dm_be    <= be_c;
      res_q    <= '0;
    end else if (bus_done) begin
      dm_req <= 1'b0;
      dm_we  <= 1'b0;
      res_q  <= is_load ? load_extend(dm_rdata, mem_ALUout[1:0], mem_size, mem_unsigned) : '0;
    end else if (bus_tmo) begin
      dm_req <= 1'b0;
      dm_we  <= 1'b0;
      res_q  <= '0;
    end
  end

  // MEM/WB outputs: one-cycle pass-through from IDLE, result from RESP,
  // bubble on every other edge so fault flags last a single cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid    <= 1'b0;
      wb_ALUout   <= '0;
      wb_rdata    <= '0;
      wb_memread  <= 1'b0;
      wb_misalign <= 1'b0;
    end else if (wb_idle) begin
      wb_valid    <= mem_valid;
      wb_ALUout   <= mem_valid ? mem_ALUout : '0;
      wb_rdata    <= '0;
      wb_memread  <= mem_valid & is_load;
      wb_misalign <= misalign;
    end else if (wb_resp) begin
      wb_valid    <= 1'b1;
      wb_ALUout   <= mem_ALUout;
      wb_rdata    <= res_q;
      wb_memread  <= is_load;
      wb_misalign <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_ALUout   <= '0;
      wb_rdata    <= '0;
      wb_memread  <= 1'b0;
      wb_misalign <= 1'b0;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        err_q;

  assign bus_tmo = (state == ST_WAIT) & ~dm_ack & (tmo_cnt == TIMEOUT - 1);

  // Wait-cycle counter, restarted for every new bus access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 tmo_cnt <= '0;
    else if (bus_start)         tmo_cnt <= '0;
    else if (state == ST_WAIT)  tmo_cnt <= tmo_cnt + 32'd1;
  end

  // Sticky-per-access timeout flag and its one-cycle write-back copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q     <= 1'b0;
      wb_buserr <= 1'b0;
    end else begin
      if (bus_start)    err_q <= 1'b0;
      else if (bus_tmo) err_q <= 1'b1;
      wb_buserr <= wb_resp & err_q;
    end
  end
`else
  logic unused_timeout;

  assign bus_tmo        = 1'b0;
  assign wb_buserr      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule
